// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared types, constants and helpers for the AES-128 key-schedule sequencer.
// The AES_KEY_CACHE_EN build uses the REPLAY state; the default build never enters it.
package aes_key_sched_ctrl_pkg;

  typedef logic [7:0]   aes_byte;
  typedef logic [31:0]  aes_word;
  typedef logic [127:0] aes_128;
  typedef logic [3:0]   aes_rk_idx;

  localparam int AES_NR = 10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    OFFER,
    SUB_REQ,
    STEP,
    DONE,
    REPLAY
  } ks_state_t;

  // GF(2^8) multiply-by-two with the AES reduction polynomial.
  function automatic aes_byte aes_xtime(input aes_byte b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Round-key stream and shared S-box port of the key-schedule sequencer.
// master = sequencer side, slave = consumer / S-box side.
interface aes_key_sched_ctrl_if;
  import aes_key_sched_ctrl_pkg::*;

  logic      rk_valid;
  logic      rk_ready;
  aes_128    rk_data;
  aes_rk_idx rk_idx;
  logic      rk_last;

  logic      sb_req;
  aes_word   sb_word;
  logic      sb_ack;
  aes_word   sb_res;

  modport master (
    output rk_valid, rk_data, rk_idx, rk_last, sb_req, sb_word,
    input  rk_ready, sb_ack, sb_res
  );

  modport slave (
    input  rk_valid, rk_data, rk_idx, rk_last, sb_req, sb_word,
    output rk_ready, sb_ack, sb_res
  );

endinterface

// File: rtl/aes_key_sched_ctrl_rcon.sv
// Rcon register: restarts at 0x01 on reset/init, doubles in GF(2^8) on advance.
module aes_rcon_gen
  import aes_key_sched_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    nrst,
  input  logic    init,
  input  logic    advance,
  output aes_byte rcon
);

  always_ff @(posedge clk) begin
    if (nrst || init) begin
      rcon <= 8'h01;
    end else if (advance) begin
      rcon <= aes_xtime(rcon);
    end
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Sequencer for an AES-128 round-key generator: loads the key, steps NR rounds and streams round keys.
// Define AES_KEY_CACHE_EN to keep every round key and allow a reverse-order replay without regeneration.
module aes_key_sched_ctrl
  import aes_key_sched_ctrl_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic    clk,
  input  logic    nrst,
  input  logic    start,
  input  aes_128  key_i,
  output logic    busy,
  output logic    done,
  output logic    kg_en,
  output logic    kg_gen_key,
  output logic    kg_next_rnd,
  output aes_byte kg_r_con,
  output aes_word kg_sub_i,
  input  aes_word kg_sub_o,
  input  aes_128  kg_key_o,
  output aes_128  kg_key_i,
  aes_key_sched_ctrl_if.master bus,
  input  logic    replay,
  output logic    cache_valid
);

  localparam aes_rk_idx LAST_IDX = aes_rk_idx'(NR);

  ks_state_t state, state_d;
  aes_rk_idx idx, idx_d;
  aes_word   sub_reg, sub_d;
  aes_128    key_reg, key_d;
  aes_byte   rcon;
  logic      rcon_init, rcon_adv;

  logic      busy_q, done_q, gen_key_q, next_rnd_q, sb_req_q, rk_valid_q, rk_last_q;
  logic      busy_d, done_d, gen_key_d, next_rnd_d, sb_req_d, rk_valid_d, rk_last_d;
  aes_byte   r_con_q, r_con_d;
  aes_word   sb_word_q, sb_word_d;
  logic      cache_valid_q;
  aes_128    cache_rd;

  aes_rcon_gen u_rcon (
    .clk     (clk),
    .nrst    (nrst),
    .init    (rcon_init),
    .advance (rcon_adv),
    .rcon    (rcon)
  );

  // Next state plus the next value of every registered output, derived from state_d.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    sub_d     = sub_reg;
    key_d     = key_reg;
    rcon_init = 1'b0;
    rcon_adv  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          key_d   = key_i;
        end else if (replay && cache_valid_q) begin
          state_d = REPLAY;
          idx_d   = LAST_IDX;
        end
      end
      LOAD: state_d = OFFER;
      OFFER: begin
        if (bus.rk_ready) begin
          state_d = (idx == LAST_IDX) ? DONE : SUB_REQ;
        end
      end
      SUB_REQ: begin
        if (bus.sb_ack) begin
          sub_d   = bus.sb_res;
          state_d = STEP;
        end
      end
      STEP: begin
        rcon_adv = 1'b1;
        idx_d    = idx + 4'd1;
        state_d  = OFFER;
      end
      DONE: begin
        rcon_init = 1'b1;
        idx_d     = '0;
        state_d   = IDLE;
      end
      REPLAY: begin
        if (bus.rk_ready) begin
          if (idx == '0) begin
            state_d = DONE;
          end else begin
            idx_d = idx - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Replay is a pure readout, so the generator enable stays low during it.
    busy_d     = state_d inside {LOAD, OFFER, SUB_REQ, STEP};
    done_d     = (state_d == DONE);
    gen_key_d  = (state_d == LOAD);
    next_rnd_d = (state_d == STEP);
    r_con_d    = (state_d == LOAD) ? 8'h01 : ((state_d == STEP) ? rcon : 8'h00);
    sb_req_d   = (state_d == SUB_REQ);
    sb_word_d  = (state_d == SUB_REQ) ? ((state == SUB_REQ) ? sb_word_q : kg_sub_o) : '0;
    rk_valid_d = state_d inside {OFFER, REPLAY};
    rk_last_d  = ((state_d == OFFER) && (idx_d == LAST_IDX)) ||
                 ((state_d == REPLAY) && (idx_d == '0));
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state      <= IDLE;
      idx        <= '0;
      sub_reg    <= '0;
      key_reg    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      gen_key_q  <= 1'b0;
      next_rnd_q <= 1'b0;
      r_con_q    <= '0;
      sb_req_q   <= 1'b0;
      sb_word_q  <= '0;
      rk_valid_q <= 1'b0;
      rk_last_q  <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      sub_reg    <= sub_d;
      key_reg    <= key_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      gen_key_q  <= gen_key_d;
      next_rnd_q <= next_rnd_d;
      r_con_q    <= r_con_d;
      sb_req_q   <= sb_req_d;
      sb_word_q  <= sb_word_d;
      rk_valid_q <= rk_valid_d;
      rk_last_q  <= rk_last_d;
    end
  end

`ifdef AES_KEY_CACHE_EN
  aes_128 cache [0:NR];

  // Contents need no reset: cache_valid gates every read of them.
  always_ff @(posedge clk) begin
    if (!nrst && (state == OFFER) && bus.rk_ready) begin
      cache[idx] <= kg_key_o;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      cache_valid_q <= 1'b0;
    end else if ((state == IDLE) && start) begin
      cache_valid_q <= 1'b0;
    end else if (state_d == DONE) begin
      cache_valid_q <= 1'b1;
    end
  end

  assign cache_rd = cache[idx];
`else
  assign cache_valid_q = 1'b0;
  assign cache_rd      = '0;
`endif

  // The generator's key register is stable while OFFER waits, so it is streamed directly.
  assign bus.rk_data  = !rk_valid_q ? '0 : ((state == REPLAY) ? cache_rd : kg_key_o);
  assign bus.rk_idx   = rk_valid_q ? idx : '0;
  assign bus.rk_valid = rk_valid_q;
  assign bus.rk_last  = rk_last_q;
  assign bus.sb_req   = sb_req_q;
  assign bus.sb_word  = sb_word_q;

  assign busy        = busy_q;
  assign kg_en       = busy_q;
  assign done        = done_q;
  assign kg_gen_key  = gen_key_q;
  assign kg_next_rnd = next_rnd_q;
  assign kg_r_con    = r_con_q;
  assign kg_sub_i    = sub_reg;
  assign kg_key_i    = key_reg;
  assign cache_valid = cache_valid_q;

endmodule
